// File: rtl/add_pipe_seg.sv
// Segmented pipelined adder/subtractor: one SEG-bit ripple segment per stage, carry registered between stages.
// Latency NSEG register stages: an op accepted at edge t presents o_valid after edge t+NSEG-1.
// Per-stage valid with a collapsing enable chain; o_ready falls only when every stage is full and i_ready=0.
module add_pipe_seg #(
    parameter int W   = 48,
    parameter int SEG = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data_one,
    input  logic [W-1:0] i_data_two,
    input  logic         i_carry,
    input  logic         i_sub,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_carry
);

    localparam int NSEG = (SEG >= 1) ? (W / SEG) : 1;

    // Reject geometries that do not split into whole segments.
    if (SEG < 1) begin : g_bad_seg
        $error("add_pipe_seg: SEG must be at least 1");
    end else if ((W % SEG) != 0) begin : g_bad_div
        $error("add_pipe_seg: W must be a multiple of SEG");
    end

    // Stage s holds: its valid bit, the carry out of segment s-1, the result with
    // segments 0..s-1 filled in, and the operands still needed by later stages.
    logic [NSEG:1]  v_q, v_d;
    logic [NSEG:1]  c_q, c_d;
    logic [W-1:0]   a_q [1:NSEG];
    logic [W-1:0]   a_d [1:NSEG];
    logic [W-1:0]   b_q [1:NSEG];
    logic [W-1:0]   b_d [1:NSEG];
    logic [W-1:0]   r_q [1:NSEG];
    logic [W-1:0]   r_d [1:NSEG];
    logic [NSEG:1]  en;
    logic [W-1:0]   bx;

    // Add one segment of a and b with carry-in c, merging the sum into the partial result r.
    function automatic logic [W:0] seg_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] r, input logic c, input int idx);
        logic [SEG:0]  sum;
        logic [W-1:0]  res;
        sum = {1'b0, a[idx*SEG +: SEG]} + {1'b0, b[idx*SEG +: SEG]} + {{SEG{1'b0}}, c};
        res = r;
        res[idx*SEG +: SEG] = sum[SEG-1:0];
        return {sum[SEG], res};
    endfunction

    // Enable chain from the output back to the input: an empty stage always
    // loads, a full one loads only if the stage after it moves too.
    always_comb begin
        logic e;
        e  = i_ready;
        en = '0;
        for (int s = NSEG; s >= 1; s--) begin
            e     = ~v_q[s] | e;
            en[s] = e;
        end
    end

    // Next state of every stage; data registers only load when a valid op
    // moves in, so bubbles and idle inputs leave them untouched.
    always_comb begin
        v_d = v_q;
        c_d = c_q;
        a_d = a_q;
        b_d = b_q;
        r_d = r_q;
        bx  = i_sub ? ~i_data_two : i_data_two;
        if (en[1]) begin
            v_d[1] = i_valid;
            if (i_valid) begin
                {c_d[1], r_d[1]} = seg_add(i_data_one, bx, '0, i_carry, 0);
                a_d[1]           = i_data_one;
                b_d[1]           = bx;
            end
        end
        for (int s = 2; s <= NSEG; s++) begin
            if (en[s]) begin
                v_d[s] = v_q[s-1];
                if (v_q[s-1]) begin
                    {c_d[s], r_d[s]} = seg_add(a_q[s-1], b_q[s-1], r_q[s-1], c_q[s-1], s-1);
                    a_d[s]           = a_q[s-1];
                    b_d[s]           = b_q[s-1];
                end
            end
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int s = 1; s <= NSEG; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
                r_q[s] <= '0;
            end
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
        end
    end

    assign o_ready = en[1];
    assign o_valid = v_q[NSEG];
    assign o_data  = r_q[NSEG];
    assign o_carry = c_q[NSEG];

endmodule

// File: tb/tb_add_pipe_seg.sv
// Bench for add_pipe_seg: scoreboarded stimulus over reset, ripple, subtract,
// stall, random flow control, reset with ops in flight, and a 44/11 instance.
module tb_add_pipe_seg;

    localparam int W  = 48;
    localparam int W2 = 44;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid, o_ready, i_carry, i_sub, o_valid, i_ready, o_carry;
    logic [W-1:0] a, b, o_data;

    logic          w_valid, w_oready, w_carry, w_sub, w_ovalid, w_ready, w_ocarry;
    logic [W2-1:0] w_a, w_b, w_odata;

    logic [W:0] sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    add_pipe_seg #(.W(W), .SEG(12)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_one(a), .i_data_two(b), .i_carry(i_carry), .i_sub(i_sub),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_carry(o_carry)
    );

    add_pipe_seg #(.W(W2), .SEG(11)) u_dut44 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(w_valid), .o_ready(w_oready),
        .i_data_one(w_a), .i_data_two(w_b), .i_carry(w_carry), .i_sub(w_sub),
        .o_valid(w_ovalid), .i_ready(w_ready), .o_data(w_odata), .o_carry(w_ocarry)
    );

    function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c, input logic s);
        logic [W-1:0] yy;
        yy = s ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
    endfunction

    // One clock: sample handshake on the falling edge, return just after the rising edge.
    task automatic tick(output bit acc, output bit con, output bit vld, output logic [W:0] got);
        @(negedge clk);
        acc = i_valid & o_ready;
        con = o_valid & i_ready;
        vld = o_valid;
        got = {o_carry, o_data};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit acc, con, vld;
        logic [W:0] got;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", o_valid); else n_pass++;
        n_checks++; if (o_data !== '0) $display("FAIL rst_data got %h want 0", o_data); else n_pass++;
        n_checks++; if (o_carry !== 1'b0) $display("FAIL rst_carry got %b want 0", o_carry); else n_pass++;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", o_ready); else n_pass++;
        rst_n = 1'b1;
        i_ready = 1'b0;
        i_valid = 1'b1; a = 48'd1; b = 48'd1; i_carry = 1'b0; i_sub = 1'b0;
        tick(acc, con, vld, got);
        i_valid = 1'b0;
        repeat (4) tick(acc, con, vld, got);
        n_checks++; if (o_valid !== 1'b1) $display("FAIL pre_rst_valid got %b want 1", o_valid); else n_pass++;
        n_checks++; if (o_data !== 48'd2) $display("FAIL pre_rst_data got %h want 2", o_data); else n_pass++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL async_rst_valid got %b want 0", o_valid); else n_pass++;
        n_checks++; if (o_data !== '0) $display("FAIL async_rst_data got %h want 0", o_data); else n_pass++;
        n_checks++; if (o_carry !== 1'b0) $display("FAIL async_rst_carry got %b want 0", o_carry); else n_pass++;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL async_rst_ready got %b want 1", o_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        i_ready = 1'b1;
    endtask

    task automatic test_ripple();
        bit acc, con, vld, seen;
        logic [W:0] got;
        int lat;
        i_ready = 1'b1;
        i_valid = 1'b1; a = {W{1'b1}}; b = '0; i_carry = 1'b1; i_sub = 1'b0;
        tick(acc, con, vld, got);
        i_valid = 1'b0;
        n_checks++; if (acc !== 1'b1) $display("FAIL ripple_accept got %b want 1", acc); else n_pass++;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(acc, con, vld, got);
            lat++;
            if (con) begin
                seen = 1'b1;
                n_checks++; if (got !== {1'b1, {W{1'b0}}}) $display("FAIL ripple_result got %h want %h", got, {1'b1, {W{1'b0}}}); else n_pass++;
                n_checks++; if (lat !== 4) $display("FAIL ripple_latency got %0d want 4", lat); else n_pass++;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL ripple_timeout got no o_valid want result within 20 cycles");
        end
    endtask

    task automatic test_sub();
        bit acc, con, vld;
        logic [W:0]   got, exp_v;
        logic [W-1:0] av [2];
        logic [W-1:0] bv [2];
        logic [W:0]   ev [2];
        int idx, nout;
        av[0] = 48'd5; bv[0] = 48'd7; ev[0] = {1'b0, 48'hFFFF_FFFF_FFFE};
        av[1] = 48'd7; bv[1] = 48'd5; ev[1] = {1'b1, 48'h0000_0000_0002};
        idx = 0; nout = 0;
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && (idx < 2 || sb_q.size() > 0); cyc++) begin
            if (idx < 2) begin
                i_valid = 1'b1; a = av[idx]; b = bv[idx]; i_carry = 1'b1; i_sub = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            tick(acc, con, vld, got);
            if (acc) begin sb_q.push_back(ev[idx]); idx++; end
            if (con) begin
                n_checks++;
                if (sb_q.size() == 0) $display("FAIL sub_unexpected got %h want none", got);
                else begin
                    exp_v = sb_q.pop_front();
                    nout++;
                    if (got !== exp_v) $display("FAIL sub_result got %h want %h", got, exp_v); else n_pass++;
                end
            end
        end
        i_valid = 1'b0; i_sub = 1'b0; i_carry = 1'b0;
        n_checks++; if (nout !== 2) $display("FAIL sub_count got %0d want 2", nout); else n_pass++;
    endtask

    task automatic test_stall();
        bit acc, con, vld, held_set, unstable, seen_v;
        logic [W:0]   got, held, exp_v;
        logic [W-1:0] av [8];
        logic [W-1:0] bv [8];
        logic         cv [8];
        logic         sv [8];
        logic [63:0]  r64;
        int idx, nout;
        for (int i = 0; i < 8; i++) begin
            r64 = {$urandom(), $urandom()}; av[i] = r64[W-1:0];
            r64 = {$urandom(), $urandom()}; bv[i] = r64[W-1:0];
            cv[i] = 1'($urandom_range(0, 1));
            sv[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; nout = 0; held_set = 1'b0; unstable = 1'b0; seen_v = 1'b0; held = '0;
        i_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (idx < 8) begin
                i_valid = 1'b1; a = av[idx]; b = bv[idx]; i_carry = cv[idx]; i_sub = sv[idx];
            end
            tick(acc, con, vld, got);
            if (acc) begin sb_q.push_back(ref_model(av[idx], bv[idx], cv[idx], sv[idx])); idx++; end
            if (vld) begin
                seen_v = 1'b1;
                if (held_set && got !== held) unstable = 1'b1;
                held = got; held_set = 1'b1;
            end
        end
        n_checks++; if (idx !== 4) $display("FAIL stall_accepted got %0d want 4", idx); else n_pass++;
        n_checks++; if (o_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", o_ready); else n_pass++;
        n_checks++; if (seen_v !== 1'b1) $display("FAIL stall_valid got %b want 1", seen_v); else n_pass++;
        n_checks++; if (unstable !== 1'b0) $display("FAIL stall_stable got %b want 0", unstable); else n_pass++;
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && (idx < 8 || sb_q.size() > 0); cyc++) begin
            if (idx < 8) begin
                i_valid = 1'b1; a = av[idx]; b = bv[idx]; i_carry = cv[idx]; i_sub = sv[idx];
            end else begin
                i_valid = 1'b0;
            end
            tick(acc, con, vld, got);
            if (acc) begin sb_q.push_back(ref_model(av[idx], bv[idx], cv[idx], sv[idx])); idx++; end
            if (con) begin
                n_checks++;
                if (sb_q.size() == 0) $display("FAIL stall_unexpected got %h want none", got);
                else begin
                    exp_v = sb_q.pop_front();
                    nout++;
                    if (got !== exp_v) $display("FAIL stall_result%0d got %h want %h", nout, got, exp_v); else n_pass++;
                end
            end
        end
        i_valid = 1'b0;
        n_checks++; if (nout !== 8) $display("FAIL stall_count got %0d want 8", nout); else n_pass++;
    endtask

    task automatic test_random_flow();
        bit acc, con, vld;
        logic [W:0]   got, exp_v;
        logic [63:0]  r64;
        logic [W-1:0] ca, cb;
        logic         cc, cs;
        int idx, nout, stalls;
        idx = 0; nout = 0; stalls = 0;
        r64 = {$urandom(), $urandom()}; ca = r64[W-1:0];
        r64 = {$urandom(), $urandom()}; cb = r64[W-1:0];
        cc = 1'($urandom_range(0, 1)); cs = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 400 && (idx < 30 || sb_q.size() > 0); cyc++) begin
            // First 10 ops at full rate with the sink always ready.
            i_ready = (idx < 10) ? 1'b1 : 1'($urandom_range(0, 1));
            if (idx < 30) begin
                i_valid = (idx < 10) ? 1'b1 : 1'($urandom_range(0, 1));
                a = ca; b = cb; i_carry = cc; i_sub = cs;
            end else begin
                i_valid = 1'b0;
            end
            tick(acc, con, vld, got);
            if (idx < 10 && !acc) stalls++;
            if (acc) begin
                sb_q.push_back(ref_model(ca, cb, cc, cs));
                idx++;
                r64 = {$urandom(), $urandom()}; ca = r64[W-1:0];
                r64 = {$urandom(), $urandom()}; cb = r64[W-1:0];
                cc = 1'($urandom_range(0, 1)); cs = 1'($urandom_range(0, 1));
            end
            if (con) begin
                n_checks++;
                if (sb_q.size() == 0) $display("FAIL rand_unexpected got %h want none", got);
                else begin
                    exp_v = sb_q.pop_front();
                    nout++;
                    if (got !== exp_v) $display("FAIL rand_result%0d got %h want %h", nout, got, exp_v); else n_pass++;
                end
            end
        end
        i_valid = 1'b0; i_ready = 1'b1;
        n_checks++; if (stalls !== 0) $display("FAIL b2b_stalls got %0d want 0", stalls); else n_pass++;
        n_checks++; if (nout !== 30) $display("FAIL rand_count got %0d want 30", nout); else n_pass++;
    endtask

    task automatic test_reset_inflight();
        bit acc, con, vld;
        logic [W:0] got;
        int pulses;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; a = W'(i + 10); b = W'(i); i_carry = 1'b0; i_sub = 1'b0;
            tick(acc, con, vld, got);
        end
        i_valid = 1'b0;
        tick(acc, con, vld, got);
        n_checks++; if (o_valid !== 1'b1) $display("FAIL inflight_valid got %b want 1", o_valid); else n_pass++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL inflight_rst_valid got %b want 0", o_valid); else n_pass++;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_ready = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 10; i++) begin
            tick(acc, con, vld, got);
            if (vld) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL post_rst_pulses got %0d want 0", pulses); else n_pass++;
    endtask

    task automatic test_w44();
        bit seen;
        w_ready = 1'b1;
        w_valid = 1'b1; w_a = 44'h7FF_FFFF_FFFF; w_b = 44'd1; w_carry = 1'b0; w_sub = 1'b0;
        @(negedge clk);
        n_checks++; if (w_oready !== 1'b1) $display("FAIL w44_ready got %b want 1", w_oready); else n_pass++;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (w_ovalid) begin
                seen = 1'b1;
                n_checks++; if (w_odata !== 44'h800_0000_0000) $display("FAIL w44_data got %h want 80000000000", w_odata); else n_pass++;
                n_checks++; if (w_ocarry !== 1'b0) $display("FAIL w44_carry got %b want 0", w_ocarry); else n_pass++;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL w44_timeout got no o_valid want result within 20 cycles");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_valid = 1'b0; i_ready = 1'b1; a = '0; b = '0; i_carry = 1'b0; i_sub = 1'b0;
        w_valid = 1'b0; w_ready = 1'b1; w_a = '0; w_b = '0; w_carry = 1'b0; w_sub = 1'b0;
        test_reset();
        test_ripple();
        test_sub();
        test_stall();
        test_random_flow();
        test_reset_inflight();
        test_w44();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
